sdram_bist: RTL

- Synthesizable self-checking SDRAM traffic engine. It is the parametrised successor of the simulation-only top-level SDRAM bench.
- Sits between the board top and the SDRAM controller's user port. It writes a selectable pattern over a configurable address window, reads the window back and compares every word.
- Reports pass/fail, error count and first failing address, and drives the 8 debug LEDs so the result is visible on hardware without a simulator.

---
 rtl/sdram_bist_pkg.sv | 27 ++
 rtl/sdram_bist_pattern_gen.sv | 52 +++++
 rtl/sdram_bist.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/sdram_bist_pkg.sv
// Shared encodings and constants for the SDRAM BIST traffic engine.
package sdram_bist_pkg;

  typedef enum logic [1:0] {
    MODE_ADDR  = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_WALK  = 2'd2,
    MODE_CHECK = 2'd3
  } pat_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_READ   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_REPORT = 3'd4
  } bist_state_e;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam int          HB_W      = 24;

  // Right-shifting Galois step for x^32+x^22+x^2+x+1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/sdram_bist_pattern_gen.sv
// Pattern source: one word per step, restartable with init. Used on both
// the issue side and the compare side so both walk the same sequence.
module bist_pattern_gen
  import sdram_bist_pkg::*;
#(
  parameter int          DATA_W     = 16,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_1234,
  parameter logic [31:0] START_ADDR = 32'd0
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              init,
  input  logic              step,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] data
);

  localparam int WALK_W = 5;

  logic [31:0]       idx;
  logic [31:0]       lfsr;
  logic [WALK_W-1:0] walk;

  // walk tracks idx mod DATA_W without a divider.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      walk <= '0;
      lfsr <= LFSR_SEED;
    end else if (init) begin
      idx  <= '0;
      walk <= '0;
      lfsr <= LFSR_SEED;
    end else if (step) begin
      idx  <= idx + 1'b1;
      walk <= (walk == WALK_W'(DATA_W - 1)) ? '0 : walk + 1'b1;
      lfsr <= lfsr_next(lfsr);
    end
  end

  always_comb begin
    data = '0;
    case (mode)
      MODE_ADDR:  data = DATA_W'(START_ADDR + idx);
      MODE_LFSR:  data = lfsr[DATA_W-1:0];
      MODE_WALK:  data = DATA_W'(1) << walk;
      MODE_CHECK: data = idx[0] ? DATA_W'(32'hAAAA_AAAA) : DATA_W'(32'h5555_5555);
      default:    data = '0;
    endcase
  end

endmodule

// File: rtl/sdram_bist.sv
// SDRAM traffic engine: writes a pattern over a window, reads it back,
// compares every word and reports the result on status outputs and LEDs.
module sdram_bist
  import sdram_bist_pkg::*;
#(
  parameter int          DATA_W          = 16,
  parameter int          ADDR_W          = 24,
  parameter logic [31:0] START_ADDR      = 32'd0,
  parameter int          NUM_WORDS       = 1024,
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [31:0] LFSR_SEED       = 32'hACE1_1234,
  parameter int          ERR_CNT_W       = 16
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic                 loop_en,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic                 cmd_we,
  output logic [ADDR_W-1:0]    cmd_addr,
  output logic [DATA_W-1:0]    cmd_wdata,
  input  logic                 rd_valid,
  input  logic [DATA_W-1:0]    rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [ADDR_W-1:0]    first_err_addr,
  output logic [15:0]          pass_cnt,
  output logic [7:0]           debug_led,
  output logic [2:0]           dbg_state
);

  localparam int CNT_W = $clog2(NUM_WORDS + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  bist_state_e       state;
  logic [1:0]        mode_q;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  rsp_cnt;
  logic [ADDR_W-1:0] rsp_addr;
  logic [OUT_W-1:0]  outstanding;
  logic [HB_W-1:0]   hb_cnt;
  logic              hb;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] exp_data;
  logic              cmd_hs;
  logic              rsp_fire;
  logic              gen_init;

  // Handshake: a command transfers on a cycle where cmd_valid && cmd_ready;
  // until then cmd_we/cmd_addr/cmd_wdata hold. rd_valid carries one in-order
  // response per cycle and has no back-pressure.
  assign cmd_valid = (state == ST_WRITE) ||
                     ((state == ST_READ) && (outstanding < OUT_W'(MAX_OUTSTANDING)));
  assign cmd_we    = (state == ST_WRITE);
  assign cmd_wdata = (state == ST_WRITE) ? wr_data : '0;
  assign cmd_hs    = cmd_valid && cmd_ready;
  // Responses only count while a read is actually outstanding in READ/DRAIN.
  assign rsp_fire  = rd_valid && ((state == ST_READ) || (state == ST_DRAIN)) &&
                     (outstanding != '0);
  assign gen_init  = ((state == ST_IDLE) && start) || ((state == ST_REPORT) && loop_en);
  assign debug_led = {pass_cnt[1:0], mode_q, hb, (err_cnt != '0), pass, busy};
  assign dbg_state = state;

  bist_pattern_gen #(
    .DATA_W(DATA_W), .LFSR_SEED(LFSR_SEED), .START_ADDR(START_ADDR)
  ) u_wr_gen (
    .sys_clk(sys_clk), .rst(rst), .init(gen_init),
    .step(cmd_hs && (state == ST_WRITE)), .mode(mode_q), .data(wr_data)
  );

  bist_pattern_gen #(
    .DATA_W(DATA_W), .LFSR_SEED(LFSR_SEED), .START_ADDR(START_ADDR)
  ) u_cmp_gen (
    .sys_clk(sys_clk), .rst(rst), .init(gen_init),
    .step(rsp_fire), .mode(mode_q), .data(exp_data)
  );

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else if (cmd_hs && !cmd_we && !rsp_fire) begin
      outstanding <= outstanding + 1'b1;
    end else if (rsp_fire && !(cmd_hs && !cmd_we)) begin
      outstanding <= outstanding - 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      hb_cnt <= '0;
      hb     <= 1'b0;
    end else begin
      hb_cnt <= hb_cnt + 1'b1;
      if (hb_cnt == '1) hb <= ~hb;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      mode_q         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      pass_cnt       <= '0;
      cmd_addr       <= '0;
      issue_cnt      <= '0;
      rsp_cnt        <= '0;
      rsp_addr       <= '0;
    end else begin
      done <= 1'b0;
      if (rsp_fire) begin
        rsp_cnt  <= rsp_cnt + 1'b1;
        rsp_addr <= rsp_addr + 1'b1;
        if (rd_data != exp_data) begin
          if (err_cnt == '0) first_err_addr <= rsp_addr;
          if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q         <= mode;
            err_cnt        <= '0;
            first_err_addr <= '0;
            busy           <= 1'b1;
            cmd_addr       <= ADDR_W'(START_ADDR);
            issue_cnt      <= '0;
            rsp_cnt        <= '0;
            rsp_addr       <= ADDR_W'(START_ADDR);
            state          <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (cmd_hs) begin
            if (issue_cnt == CNT_W'(NUM_WORDS - 1)) begin
              issue_cnt <= '0;
              cmd_addr  <= ADDR_W'(START_ADDR);
              state     <= ST_READ;
            end else begin
              issue_cnt <= issue_cnt + 1'b1;
              cmd_addr  <= cmd_addr + 1'b1;
            end
          end
        end
        ST_READ: begin
          if (cmd_hs) begin
            cmd_addr <= cmd_addr + 1'b1;
            if (issue_cnt == CNT_W'(NUM_WORDS - 1)) begin
              state <= ST_DRAIN;
            end else begin
              issue_cnt <= issue_cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (rsp_cnt == CNT_W'(NUM_WORDS)) state <= ST_REPORT;
        end
        ST_REPORT: begin
          done     <= 1'b1;
          pass     <= (err_cnt == '0);
          pass_cnt <= pass_cnt + 1'b1;
          if (loop_en) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
            cmd_addr       <= ADDR_W'(START_ADDR);
            issue_cnt      <= '0;
            rsp_cnt        <= '0;
            rsp_addr       <= ADDR_W'(START_ADDR);
            state          <= ST_WRITE;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
